// File: rtl/sfu_fp_pkg.sv
// Shared FP32 definitions for the SFU softmax datapath: field widths, field view,
// capture/replay state encoding and the sign-magnitude compare key.
package sfu_fp_pkg;

    localparam int          FP32_EXPO_WIDTH = 8;
    localparam int          FP32_MANT_WIDTH = 23;
    localparam logic [31:0] FP32_POS_ZERO   = 32'h0000_0000;

    typedef struct packed {
        logic                       sign;
        logic [FP32_EXPO_WIDTH-1:0] exp;
        logic [FP32_MANT_WIDTH-1:0] mant;
    } fp32_t;

    typedef enum logic [0:0] {
        CAPTURE = 1'b0,
        REPLAY  = 1'b1
    } fsm_state_e;

    // Orders FP32 values as unsigned keys; only meaningful once -0 has been flushed to +0.
    function automatic logic [31:0] fp32_key(input logic [31:0] bits);
        return bits[31] ? ~bits : (bits | 32'h8000_0000);
    endfunction

endpackage

// File: rtl/fp32_sub_nonpos.sv
// Single registered stage computing x - max for x <= max (truncating, flush-to-zero),
// with vld/last carried alongside; SOFTMAX_MAX_OUT_EN also registers the max as max_o.
module fp32_sub_nonpos
    import sfu_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = FP32_EXPO_WIDTH,
    parameter int MANT_WIDTH = FP32_MANT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  vld_i,
    input  logic                  last_i,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic [DATA_WIDTH-1:0] max_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  vld_o,
    output logic                  last_o
`ifdef SOFTMAX_MAX_OUT_EN
   ,output logic [DATA_WIDTH-1:0] max_o
`endif
);

    localparam int SIG_W = MANT_WIDTH + 1;
    localparam int LZ_W  = $clog2(SIG_W + 1);

    fp32_t                 xF, mF;
    logic                  addMode;
    logic [EXPO_WIDTH-1:0] bigExp, smallExp, expDiff;
    logic [MANT_WIDTH-1:0] bigMant, smallMant, normMant;
    logic [SIG_W-1:0]      bigSig, smallSig, smallAligned;
    logic [SIG_W:0]        rawSum;
    logic [LZ_W-1:0]       lz;
    logic [EXPO_WIDTH+1:0] normExp;
    logic [DATA_WIDTH-1:0] result_d, result_q;
    logic                  vld_q, last_q;
`ifdef SOFTMAX_MAX_OUT_EN
    logic [DATA_WIDTH-1:0] max_q;
`endif

    function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(SIG_W);
        for (int i = 0; i < SIG_W; i++) begin
            if (v[i]) n = LZ_W'(SIG_W - 1 - i);
        end
        return n;
    endfunction

    assign xF = x_i;
    assign mF = max_i;

    // Differing signs mean a negative x minus a non-negative max: magnitudes add.
    always_comb begin
        addMode = xF.sign ^ mF.sign;
        if ({xF.exp, xF.mant} >= {mF.exp, mF.mant}) begin
            bigExp    = xF.exp;
            bigMant   = xF.mant;
            smallExp  = mF.exp;
            smallMant = mF.mant;
        end else begin
            bigExp    = mF.exp;
            bigMant   = mF.mant;
            smallExp  = xF.exp;
            smallMant = xF.mant;
        end
        bigSig       = {|bigExp, bigMant};
        smallSig     = {|smallExp, smallMant};
        expDiff      = bigExp - smallExp;
        smallAligned = smallSig >> expDiff;
        rawSum       = addMode ? ({1'b0, bigSig} + {1'b0, smallAligned})
                               : ({1'b0, bigSig} - {1'b0, smallAligned});
        lz           = lzc(rawSum[SIG_W-1:0]);
        normMant     = MANT_WIDTH'(rawSum[SIG_W-1:0] << lz);
        normExp      = {2'b00, bigExp} - (EXPO_WIDTH+2)'(lz);
        result_d     = FP32_POS_ZERO;
        if (rawSum[SIG_W]) begin
            result_d = {1'b1, bigExp + 1'b1, rawSum[SIG_W-1:1]};
        end else if (rawSum != '0 && !normExp[EXPO_WIDTH+1] && normExp != '0) begin
            result_d = {1'b1, normExp[EXPO_WIDTH-1:0], normMant};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            result_q <= FP32_POS_ZERO;
`ifdef SOFTMAX_MAX_OUT_EN
            max_q    <= FP32_POS_ZERO;
`endif
        end else if (en) begin
            vld_q  <= vld_i;
            last_q <= vld_i & last_i;
            if (vld_i) begin
                result_q <= result_d;
`ifdef SOFTMAX_MAX_OUT_EN
                max_q    <= max_i;
`endif
            end
        end
    end

    assign result_o = result_q;
    assign vld_o    = vld_q;
    assign last_o   = last_q;
`ifdef SOFTMAX_MAX_OUT_EN
    assign max_o    = max_q;
`endif

endmodule

// File: rtl/softmax_max_sub.sv
// Captures an FP32 score vector, tracks its maximum, then replays x_i - max into the
// exponential unit. Optional port max_out is enabled by SOFTMAX_MAX_OUT_EN.
module softmax_max_sub
    import sfu_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23,
    parameter int LEN        = 16,
    parameter int CNT_WIDTH  = $clog2(LEN) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  vld_in,
    output logic                  rdy_in,
    input  logic                  last_in,
    input  logic [DATA_WIDTH-1:0] Oprand_A,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  vld_out,
    output logic                  last_out
`ifdef SOFTMAX_MAX_OUT_EN
   ,output logic [DATA_WIDTH-1:0] max_out
`endif
);

    localparam int IDX_WIDTH = $clog2(LEN);

    logic [DATA_WIDTH-1:0] bufMem [LEN];
    fsm_state_e            state_q;
    logic [CNT_WIDTH-1:0]  count_q, rd_q;
    logic [DATA_WIDTH-1:0] max_q;
    logic                  rdy_q;

    logic [DATA_WIDTH-1:0] inFlushed;
    logic                  transfer, captureLast, issueVld, issueLast;

    assign inFlushed   = (Oprand_A[MANT_WIDTH +: EXPO_WIDTH] == '0) ? FP32_POS_ZERO : Oprand_A;
    assign transfer    = vld_in & rdy_q & en;
    assign captureLast = last_in | (count_q == CNT_WIDTH'(LEN - 1));
    assign issueVld    = (state_q == REPLAY);
    assign issueLast   = (rd_q == count_q - 1'b1);

    always_ff @(posedge clk) begin
        if (rst_n && transfer) begin
            bufMem[count_q[IDX_WIDTH-1:0]] <= inFlushed;
        end
    end

    // rdy_q is refreshed even while stalled so it rises the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CAPTURE;
            count_q <= '0;
            rd_q    <= '0;
            max_q   <= FP32_POS_ZERO;
            rdy_q   <= 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    rdy_q <= 1'b1;
                    if (transfer) begin
                        count_q <= count_q + 1'b1;
                        if (count_q == '0 || fp32_key(inFlushed) > fp32_key(max_q)) begin
                            max_q <= inFlushed;
                        end
                        if (captureLast) begin
                            state_q <= REPLAY;
                            rdy_q   <= 1'b0;
                        end
                    end
                end
                REPLAY: begin
                    rdy_q <= 1'b0;
                    if (en) begin
                        if (issueLast) begin
                            state_q <= CAPTURE;
                            count_q <= '0;
                            rd_q    <= '0;
                            rdy_q   <= 1'b1;
                        end else begin
                            rd_q <= rd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= CAPTURE;
                    rdy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rdy_in = rdy_q;

    fp32_sub_nonpos #(
        .DATA_WIDTH (DATA_WIDTH),
        .EXPO_WIDTH (EXPO_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) u_sub (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .vld_i    (issueVld),
        .last_i   (issueLast),
        .x_i      (bufMem[rd_q[IDX_WIDTH-1:0]]),
        .max_i    (max_q),
        .result_o (Result),
        .vld_o    (vld_out),
        .last_o   (last_out)
`ifdef SOFTMAX_MAX_OUT_EN
       ,.max_o    (max_out)
`endif
    );

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub: expected results are queued as vectors are driven
// and an output monitor pops and compares them whenever a new result is produced.
module tb_softmax_max_sub;

    typedef struct packed {
        logic [31:0] res;
        logic        last;
    } exp_t;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b1;
    logic        vld_in   = 1'b0;
    logic        last_in  = 1'b0;
    logic [31:0] Oprand_A = '0;
    logic        rdy_in;
    logic [31:0] Result;
    logic        vld_out;
    logic        last_out;
`ifdef SOFTMAX_MAX_OUT_EN
    logic [31:0] maxOut;
`endif

    exp_t sb[$];
    exp_t item;
    exp_t holdItem;
    logic holdValid = 1'b0;
    logic enAtEdge  = 1'b0;
    logic rstAtEdge = 1'b0;
    logic toggleEn  = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    softmax_max_sub dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .vld_in   (vld_in),
        .rdy_in   (rdy_in),
        .last_in  (last_in),
        .Oprand_A (Oprand_A),
        .Result   (Result),
        .vld_out  (vld_out),
        .last_out (last_out)
`ifdef SOFTMAX_MAX_OUT_EN
       ,.max_out  (maxOut)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fpInt(input int v);
        int          a;
        int          e;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        e = 0;
        while ((a >> (e + 1)) != 0) e++;
        m = 32'(a) << (23 - e);
        return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + e), m[22:0]};
    endfunction

    task automatic pushExp(input logic [31:0] res, input logic last);
        exp_t e;
        e.res  = res;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic sendElem(input logic [31:0] d, input logic l);
        int n = 0;
        vld_in   = 1'b1;
        Oprand_A = d;
        last_in  = l;
        while (!(rdy_in === 1'b1 && en === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("[TB] FAIL send_timeout: observed %0d cycles expected below 200", n);
        end
        @(negedge clk);
        vld_in  = 1'b0;
        last_in = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL drain_timeout: observed %0d pending expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // en moves well after the rising edge so stimulus and monitor see it settled.
    initial forever begin
        @(posedge clk);
        #2;
        en = toggleEn ? ~en : 1'b1;
    end

    always @(posedge clk) begin
        enAtEdge  <= en;
        rstAtEdge <= rst_n;
    end

    // A new result exists only after an enabled, non-reset edge; otherwise it must hold.
    always @(negedge clk) begin
        if (rstAtEdge && enAtEdge) begin
            if (vld_out === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL unexpected_output: observed %h expected no output", Result);
                end
                if (sb.size() != 0) begin
                    item = sb.pop_front();
                    checkWord("result", Result, item.res);
                    checkBit("last_out", last_out, item.last);
                    holdItem  = item;
                    holdValid = 1'b1;
                end
            end else begin
                holdValid = 1'b0;
            end
        end else if (rstAtEdge && !enAtEdge) begin
            if (holdValid) begin
                checkBit("hold_vld", vld_out, 1'b1);
                checkWord("hold_result", Result, holdItem.res);
                checkBit("hold_last", last_out, holdItem.last);
            end
        end else begin
            holdValid = 1'b0;
        end
    end

    initial begin
        int lowCnt;

        repeat (3) @(negedge clk);
        checkBit("reset_rdy", rdy_in, 1'b0);
        checkBit("reset_vld", vld_out, 1'b0);
        checkBit("reset_last", last_out, 1'b0);
        checkWord("reset_result", Result, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("rdy_after_reset", rdy_in, 1'b1);

        // [1.0, 3.0, 2.0]
        pushExp(32'hC000_0000, 1'b0);
        pushExp(32'h0000_0000, 1'b0);
        pushExp(32'hBF80_0000, 1'b1);
        sendElem(32'h3F80_0000, 1'b0);
        sendElem(32'h4040_0000, 1'b0);
        sendElem(32'h4000_0000, 1'b1);
        checkBit("t1_vld_before_issue", vld_out, 1'b0);
        lowCnt = 0;
        while (rdy_in === 1'b0 && lowCnt < 20) begin
            lowCnt++;
            @(negedge clk);
            if (lowCnt == 1) checkBit("t1_first_vld", vld_out, 1'b1);
        end
        checkWord("t1_rdy_low_cycles", lowCnt, 32'd3);
        waitDrain();

        // [-1.0, -4.0]
        pushExp(32'h0000_0000, 1'b0);
        pushExp(32'hC040_0000, 1'b1);
        sendElem(32'hBF80_0000, 1'b0);
        sendElem(32'hC080_0000, 1'b1);
        waitDrain();

        // 0.0 .. 15.0 with no last_in: the 16th element closes the vector
        for (int k = 0; k < 16; k++) pushExp(fpInt(k - 15), (k == 15));
        for (int k = 0; k < 16; k++) sendElem(fpInt(k), 1'b0);
        waitDrain();

        // [2.0, 0.5] with en toggling through capture and replay
        toggleEn = 1'b1;
        pushExp(32'h0000_0000, 1'b0);
        pushExp(32'hBFC0_0000, 1'b1);
        sendElem(32'h4000_0000, 1'b0);
        sendElem(32'h3F00_0000, 1'b1);
        waitDrain();
        toggleEn = 1'b0;
        repeat (2) @(negedge clk);

        // denormal and -0 are flushed before compare and storage
        pushExp(32'hBF80_0000, 1'b0);
        pushExp(32'hBF80_0000, 1'b0);
        pushExp(32'h0000_0000, 1'b1);
        sendElem(32'h0000_0001, 1'b0);
        sendElem(32'h8000_0000, 1'b0);
        sendElem(32'h3F80_0000, 1'b1);
        waitDrain();

        // reset one cycle into replay of [4.0, 1.0, 2.0, 3.0]: only the first result escapes
        pushExp(32'h0000_0000, 1'b0);
        sendElem(32'h4080_0000, 1'b0);
        sendElem(32'h3F80_0000, 1'b0);
        sendElem(32'h4000_0000, 1'b0);
        sendElem(32'h4040_0000, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkBit("t6_vld_after_reset", vld_out, 1'b0);
        checkBit("t6_last_after_reset", last_out, 1'b0);
        checkBit("t6_rdy_in_reset", rdy_in, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("t6_rdy_after_reset", rdy_in, 1'b1);
        checkWord("t6_pending_after_reset", sb.size(), 32'd0);
        pushExp(32'h0000_0000, 1'b1);
        sendElem(32'h40A0_0000, 1'b1);
        waitDrain();

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("[TB] FAIL final_queue: observed %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
